pc_update: RTL and testbench
============================

PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the PC value after reset.
REQ-002 SHALL have port clk, input, 1, the single system clock; reset is synchronous and active-high.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port state, input, 1, 0 = FETCH, 1 = EXEC.
REQ-005 SHALL have port stall, input, 1, high while a memory access holds the pipeline.
REQ-006 SHALL have port jump_addr_selection, input, 2, registered branch decision: 00 none, 01 register-absolute, 10 page-absolute, 11 PC-relative.
REQ-007 SHALL have port instruction_word, input, 32, instruction currently in EXEC.
REQ-008 SHALL have port rs_data, input, 32, register-file rs value for the EXEC instruction.
REQ-009 SHALL have port pc, output, 32, address of the current instruction.
REQ-010 SHALL have port pc_plus8, output, 32, link address (pc+8), combinational.
REQ-011 SHALL have port active, output, 1, low once the CPU has halted.

Function
REQ-012 An EXEC commit SHALL mean a rising clk edge with state=1, stall=0, active=1 and reset=0; all registers SHALL hold on every other edge.
REQ-013 At each commit the block SHALL latch three candidate targets from the EXEC instruction: rel_tgt = pc+4+(sign-extended instruction_word[15:0]<<2); page_tgt = {pc_plus4[31:28], instruction_word[25:0], 2'b00}; abs_tgt = rs_data.
REQ-014 At each commit, with sel_valid=1 and jump_addr_selection != 00, pc SHALL load the previously latched target chosen by jump_addr_selection; otherwise pc SHALL load pc+4.
REQ-015 Because of REQ-013 and REQ-014, the jump SHALL take effect after the delay-slot instruction's commit, never after the branch's own commit.
REQ-016 sel_valid SHALL clear on reset and set on the first commit, so a stale jump_addr_selection is ignored for the first commit after reset.
REQ-017 At a commit where pc loads 32'h00000000 by jump, active SHALL go low at the same edge; pc and all latches SHALL then freeze until reset.
REQ-018 All address arithmetic SHALL be modulo 2^32; a relative target that wraps SHALL wrap silently.
REQ-019 stall=1 during EXEC SHALL hold pc, all latched targets and sel_valid unchanged.
REQ-020 The FETCH state SHALL never modify any register.

Reset
REQ-021 On reset: pc = RESET_VECTOR, rel_tgt/page_tgt/abs_tgt = 0, sel_valid = 0, active = 1; pc_plus8 = RESET_VECTOR+8.
REQ-022 Reset asserted mid-operation, including in a delay slot, SHALL discard any pending jump.

Structure
REQ-023 RESET_VECTOR default and the jump_addr_selection encoding, as a 2-bit enum (JSEL_NONE, JSEL_ABS, JSEL_PAGE, JSEL_REL), SHALL live in shared package mips_pkg.
REQ-024 Target computation SHALL be a combinational sub-module pc_target_gen (inputs pc, instruction_word, rs_data; outputs the three targets).

Verification
REQ-025 Reset, then three commits with sel=00 -> pc = BFC00000, then BFC00004, BFC00008, BFC0000C; active=1.
REQ-026 BEQ at pc=BFC00010 with imm 0003 commits, then sel=11 during the delay slot -> pc = BFC00014, then BFC00020.
REQ-027 Branch at pc=BFC00100 with imm FFFE, sel=11 on the next commit -> pc = BFC00104, then BFC000FC.
REQ-028 J at pc=BFC00200 with index 0000040, sel=10 -> pc = BFC00204, then B0000100.
REQ-029 JR with rs_data=0, sel=01 -> after the delay-slot commit pc = 00000000, active=0; five further EXEC cycles leave pc at 0.
REQ-030 Stall=1 for 4 EXEC cycles between a branch and its delay slot -> pc and targets unchanged; the jump lands correctly after the stall.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and jump-select encoding for the fetch path
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        JSEL_NONE = 2'b00,
        JSEL_ABS  = 2'b01,
        JSEL_PAGE = 2'b10,
        JSEL_REL  = 2'b11
    } jsel_e;

endpackage

// File: rtl/pc_target_gen.sv
// rtl/pc_target_gen.sv - combinational branch/jump target candidates for the EXEC instruction
module pc_target_gen (
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] rel_tgt_o,
    output logic [31:0] page_tgt_o,
    output logic [31:0] abs_tgt_o
);

    logic [31:0] pc_plus4;
    logic [31:0] rel_offset;
    logic        unused_opcode;

    assign pc_plus4   = pc_i + 32'd4;
    // Immediate is a word offset: sign-extend and scale to bytes in one concatenation.
    assign rel_offset = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

    assign rel_tgt_o  = pc_plus4 + rel_offset;
    assign page_tgt_o = {pc_plus4[31:28], instr_i[25:0], 2'b00};
    assign abs_tgt_o  = rs_data_i;

    assign unused_opcode = ^instr_i[31:26];

endmodule

// File: rtl/pc_update.sv
// rtl/pc_update.sv - program counter with one-slot delayed jump and halt-on-zero
module pc_update
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        state,
    input  logic        stall,
    input  logic [1:0]  jump_addr_selection,
    input  logic [31:0] instruction_word,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        active
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rel_q, rel_d;
    logic [31:0] page_q, page_d;
    logic [31:0] abs_q, abs_d;
    logic        sel_valid_q, sel_valid_d;
    logic        active_q, active_d;

    logic [31:0] rel_c, page_c, abs_c;
    logic [31:0] jump_tgt;
    logic        commit;
    logic        take_jump;
    jsel_e       jsel;

    pc_target_gen u_target_gen (
        .pc_i       (pc_q),
        .instr_i    (instruction_word),
        .rs_data_i  (rs_data),
        .rel_tgt_o  (rel_c),
        .page_tgt_o (page_c),
        .abs_tgt_o  (abs_c)
    );

    assign jsel      = jsel_e'(jump_addr_selection);
    assign commit    = state && !stall && active_q;
    assign take_jump = sel_valid_q && (jsel != JSEL_NONE);

    // The selection arriving now refers to the branch committed one slot ago,
    // so it picks among targets latched at that earlier commit.
    always_comb begin
        jump_tgt = pc_q + 32'd4;
        unique case (jsel)
            JSEL_ABS:  jump_tgt = abs_q;
            JSEL_PAGE: jump_tgt = page_q;
            JSEL_REL:  jump_tgt = rel_q;
            JSEL_NONE: jump_tgt = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        rel_d       = rel_q;
        page_d      = page_q;
        abs_d       = abs_q;
        sel_valid_d = sel_valid_q;
        active_d    = active_q;
        if (commit) begin
            pc_d        = take_jump ? jump_tgt : pc_q + 32'd4;
            rel_d       = rel_c;
            page_d      = page_c;
            abs_d       = abs_c;
            sel_valid_d = 1'b1;
            if (take_jump && (jump_tgt == 32'd0)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            rel_q       <= 32'd0;
            page_q      <= 32'd0;
            abs_q       <= 32'd0;
            sel_valid_q <= 1'b0;
            active_q    <= 1'b1;
        end else begin
            pc_q        <= pc_d;
            rel_q       <= rel_d;
            page_q      <= page_d;
            abs_q       <= abs_d;
            sel_valid_q <= sel_valid_d;
            active_q    <= active_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus8 = pc_q + 32'd8;
    assign active   = active_q;

endmodule

// File: tb/tb_pc_update.sv
// tb/tb_pc_update.sv - directed and randomized checks of pc_update against a reference model
module tb_pc_update;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        state;
    logic        stall;
    logic [1:0]  jump_addr_selection;
    logic [31:0] instruction_word;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        active;

    int checks = 0;
    int errors = 0;

    // Reference model: remembered target per selection code, indexed 1..3.
    logic [31:0] m_pc;
    logic [31:0] m_tgt [4];
    logic        m_armed;
    logic        m_act;

    always #5 clk = ~clk;

    pc_update #(.RESET_VECTOR(RV)) dut (
        .clk                 (clk),
        .reset               (reset),
        .state               (state),
        .stall               (stall),
        .jump_addr_selection (jump_addr_selection),
        .instruction_word    (instruction_word),
        .rs_data             (rs_data),
        .pc                  (pc),
        .pc_plus8            (pc_plus8),
        .active              (active)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic stl,
                              input logic [1:0] sel, input logic [31:0] ins, input logic [31:0] rs);
        longint      off;
        logic [31:0] nxt;
        if (rst) begin
            m_pc = RV;
            for (int i = 0; i < 4; i++) m_tgt[i] = 32'd0;
            m_armed = 1'b0;
            m_act   = 1'b1;
        end else if (st && !stl && m_act) begin
            if (m_armed && sel != 2'd0) nxt = m_tgt[sel];
            else                        nxt = m_pc + 32'd4;
            off      = longint'($signed(ins[15:0]));
            m_tgt[3] = m_pc + 32'd4 + 32'(off * 4);
            m_tgt[2] = ((m_pc + 32'd4) & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 32'd4;
            m_tgt[1] = rs;
            if (m_armed && sel != 2'd0 && nxt == 32'd0) m_act = 1'b0;
            m_pc    = nxt;
            m_armed = 1'b1;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic stl,
                        input logic [1:0] sel, input logic [31:0] ins, input logic [31:0] rs);
        reset               = rst;
        state               = st;
        stall               = stl;
        jump_addr_selection = sel;
        instruction_word    = ins;
        rs_data             = rs;
        model_edge(rst, st, stl, sel, ins, rs);
        @(posedge clk);
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus8", pc_plus8, m_pc + 32'd8);
        check_eq("active", {31'd0, active}, {31'd0, m_act});
    endtask

    task automatic commit(input logic [1:0] sel, input logic [31:0] ins, input logic [31:0] rs);
        step(1'b0, 1'b1, 1'b0, sel, ins, rs);
    endtask

    task automatic do_reset();
        step(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 2'(3), $urandom, $urandom);
    endtask

    initial begin
        do_reset();
        check_eq("reset_pc", pc, 32'hBFC0_0000);
        check_eq("reset_pc8", pc_plus8, 32'hBFC0_0008);
        check_eq("reset_active", {31'd0, active}, 32'd1);

        // Stale selection on first commit after reset is ignored.
        commit(2'b11, 32'h1000_0100, 32'h0);
        check_eq("first_commit_ignores_sel", pc, 32'hBFC0_0004);
        commit(2'b00, 32'h0, 32'h0);
        commit(2'b00, 32'h0, 32'h0);
        check_eq("seq_pc", pc, 32'hBFC0_000C);
        check_eq("seq_active", {31'd0, active}, 32'd1);

        // FETCH cycles never move anything.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom_range(0, 1), 2'(3), $urandom, $urandom);
        check_eq("fetch_hold", pc, 32'hBFC0_000C);

        // Forward branch at BFC00010, imm 3.
        commit(2'b00, 32'h0, 32'h0);
        commit(2'b00, 32'h1000_0003, 32'h0);
        check_eq("beq_delay_slot", pc, 32'hBFC0_0014);
        commit(2'b11, 32'h0, 32'h0);
        check_eq("beq_target", pc, 32'hBFC0_0020);

        // Page jump to BFC00100, then backward branch imm FFFE.
        commit(2'b00, 32'h0BF0_0040, 32'h0);
        commit(2'b10, 32'h0, 32'h0);
        check_eq("page_to_100", pc, 32'hBFC0_0100);
        commit(2'b00, 32'h1000_FFFE, 32'h0);
        check_eq("bwd_delay_slot", pc, 32'hBFC0_0104);
        commit(2'b11, 32'h0, 32'h0);
        check_eq("bwd_target", pc, 32'hBFC0_00FC);

        // Reach BFC00200, then J with index 0000040.
        commit(2'b00, 32'h0BF0_0080, 32'h0);
        commit(2'b10, 32'h0, 32'h0);
        check_eq("page_to_200", pc, 32'hBFC0_0200);
        commit(2'b00, 32'h0800_0040, 32'h0);
        check_eq("j_delay_slot", pc, 32'hBFC0_0204);
        commit(2'b10, 32'h0, 32'h0);
        check_eq("j_target", pc, 32'hB000_0100);

        // Branch, four stalled EXEC cycles with junk inputs, then delay slot.
        commit(2'b00, 32'h1000_0010, 32'h0);
        check_eq("stall_br_slot", pc, 32'hB000_0104);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 2'(3), $urandom, $urandom);
        check_eq("stall_hold", pc, 32'hB000_0104);
        commit(2'b11, 32'h0, 32'h0);
        check_eq("stall_target", pc, 32'hB000_0144);

        // Wrapping relative target: land at FFFFFFF0 via register jump.
        commit(2'b00, 32'h0000_0008, 32'hFFFF_FFF0);
        commit(2'b01, 32'h1000_0007, 32'h0);
        check_eq("jr_to_top", pc, 32'hFFFF_FFF0);
        commit(2'b00, 32'h1000_0007, 32'h0);
        commit(2'b11, 32'h0, 32'h0);
        check_eq("rel_wrap", pc, 32'h0000_0010);

        // Reset in a delay slot discards the pending jump.
        commit(2'b00, 32'h1000_0040, 32'h0);
        do_reset();
        commit(2'b11, 32'h0, 32'h0);
        check_eq("reset_drops_jump", pc, 32'hBFC0_0004);

        // Register jump to zero halts the core.
        commit(2'b00, 32'h0000_0008, 32'h0);
        commit(2'b01, 32'h0, 32'h0);
        check_eq("halt_pc", pc, 32'h0);
        check_eq("halt_active", {31'd0, active}, 32'd0);
        for (int i = 0; i < 5; i++) commit(2'($urandom_range(0, 3)), $urandom, $urandom);
        check_eq("halt_frozen", pc, 32'h0);
        check_eq("halt_pc8", pc_plus8, 32'h8);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 49) == 0) do_reset();
            else step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      2'($urandom_range(0, 3)), $urandom, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
